// File: rtl/rf_pkg.sv
// Shared widths, types and helpers for the bypassing register file and its busy scoreboard.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  function automatic logic isZeroAddr(input int unsigned addr);
    return addr == int'(ZERO_ADDR);
  endfunction

endpackage

// File: rtl/register_file_bypass_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback port, issue port and busy flags.
interface register_file_bypass_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::AW
);

  logic            WE3;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            ISSUE_EN;
  logic [AW-1:0]   ISSUE_RD;
  logic            BUSY1;
  logic            BUSY2;

  modport master (
    output WE3, A3, WD3, A1, A2, ISSUE_EN, ISSUE_RD,
    input  RD1, RD2, BUSY1, BUSY2
  );

  modport slave (
    input  WE3, A3, WD3, A1, A2, ISSUE_EN, ISSUE_RD,
    output RD1, RD2, BUSY1, BUSY2
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set when a producer issues, cleared at its writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG     = rf_pkg::NREG,
  parameter int AW       = rf_pkg::AW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          ISSUE_EN,
  input  logic [AW-1:0] ISSUE_RD,
  input  logic          WE3,
  input  logic [AW-1:0] A3,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic          BUSY1,
  output logic          BUSY2
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busyNext;
  logic            w_issueSet;
  logic            w_bypassEn;

  assign w_issueSet = ISSUE_EN && !((ZERO_REG != 0) && isZeroAddr(int'(ISSUE_RD)));
  assign w_bypassEn = (BYPASS != 0) && WE3;

  // Clear is applied first so a same-cycle issue to the written register keeps it busy.
  always_comb begin
    w_busyNext = r_busy;
    if (WE3) begin
      w_busyNext[A3] = 1'b0;
    end
    if (w_issueSet) begin
      w_busyNext[ISSUE_RD] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign BUSY1 = r_busy[A1] && !(w_bypassEn && (A3 == A1));
  assign BUSY2 = r_busy[A2] && !(w_bypassEn && (A3 == A2));

endmodule

// File: rtl/register_file_bypass_sb.sv
// NREG x XLEN register file: two combinational read ports with writeback bypass, hardwired r0, busy scoreboard.
module register_file_bypass_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = rf_pkg::XLEN,
  parameter int NREG     = rf_pkg::NREG,
  parameter int AW       = rf_pkg::AW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     CLR,
  register_file_bypass_sb_if.slave bus
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wrZero;
  logic            w_wrEn;
  logic            w_bypassEn;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_busy1;
  logic            w_busy2;

  assign w_wrZero   = (ZERO_REG != 0) && isZeroAddr(int'(bus.A3));
  assign w_wrEn     = bus.WE3 && !w_wrZero;
  // Gated by CLR so reads stay at zero while reset is held, even with a write pending.
  assign w_bypassEn = (BYPASS != 0) && w_wrEn && CLR;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrEn) begin
      r_regs[bus.A3] <= bus.WD3;
    end
  end

  always_comb begin
    w_rd1 = r_regs[bus.A1];
    if (w_bypassEn && (bus.A3 == bus.A1)) begin
      w_rd1 = bus.WD3;
    end
    if ((ZERO_REG != 0) && isZeroAddr(int'(bus.A1))) begin
      w_rd1 = '0;
    end
  end

  always_comb begin
    w_rd2 = r_regs[bus.A2];
    if (w_bypassEn && (bus.A3 == bus.A2)) begin
      w_rd2 = bus.WD3;
    end
    if ((ZERO_REG != 0) && isZeroAddr(int'(bus.A2))) begin
      w_rd2 = '0;
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK      (CLK),
    .CLR      (CLR),
    .ISSUE_EN (bus.ISSUE_EN),
    .ISSUE_RD (bus.ISSUE_RD),
    .WE3      (bus.WE3),
    .A3       (bus.A3),
    .A1       (bus.A1),
    .A2       (bus.A2),
    .BUSY1    (w_busy1),
    .BUSY2    (w_busy2)
  );

  assign bus.RD1   = w_rd1;
  assign bus.RD2   = w_rd2;
  assign bus.BUSY1 = w_busy1;
  assign bus.BUSY2 = w_busy2;

endmodule
